// File: rtl/alu_pkg.sv
// Shared op-codes and FSM state type for the iterative ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_DIV = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_MOD = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic op_is_divider(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; iteration count comes from the owner's counter.
module seq_divider #(
   parameter int W  = 8,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  dividend,
   input  logic [W-1:0]  divisor,
   input  logic [CW-1:0] iter_cnt,
   output logic          done,
   output logic [W-1:0]  quotient,
   output logic [W-1:0]  remainder
);

   localparam logic [CW-1:0] LAST = CW'(W);

   logic [W-1:0] quo_q, quo_d;
   logic [W-1:0] rem_q, rem_d;
   logic [W-1:0] dvs_q, dvs_d;
   logic         run_q, run_d;

   logic [W-1:0] src_quo, src_rem, src_dvs;
   logic [W:0]   shifted, trial;
   logic         fits;
   logic [W-1:0] step_quo, step_rem;

   // The start edge already performs the first iteration on the raw operands.
   always_comb begin
      src_quo  = start ? dividend : quo_q;
      src_rem  = start ? '0 : rem_q;
      src_dvs  = start ? divisor : dvs_q;
      shifted  = {src_rem, src_quo[W-1]};
      trial    = shifted - {1'b0, src_dvs};
      fits     = (shifted >= {1'b0, src_dvs});
      step_rem = fits ? trial[W-1:0] : shifted[W-1:0];
      step_quo = {src_quo[W-2:0], fits};
   end

   always_comb begin
      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      run_d = run_q;
      if (start) begin
         quo_d = step_quo;
         rem_d = step_rem;
         dvs_d = divisor;
         run_d = 1'b1;
      end else if (run_q) begin
         if (iter_cnt == LAST) begin
            run_d = 1'b0;
         end else begin
            quo_d = step_quo;
            rem_d = step_rem;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         run_q <= 1'b0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         run_q <= run_d;
      end
   end

   assign done      = run_q && (iter_cnt == LAST);
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle add/sub, shift-add multiply and restoring divide/modulo.
import alu_pkg::*;

module iter_alu #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2:0]     op,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           dz,
   output logic           err
);

   localparam int            CW   = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [W-1:0]     a_q, a_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [2*W-1:0]   result_q, result_d;
   logic             dz_q, dz_d;
   logic             err_q, err_d;

   logic             accept, go_run, run_last;
   logic             div_start, div_done;
   logic [W-1:0]     div_quo, div_rem;
   logic [W:0]       add_sum, sub_diff, psum;
   logic [2*W-1:0]   src_acc, step_acc;
   logic [W-1:0]     src_a;

   assign accept   = start && (state_q != ST_RUN);
   assign go_run   = (op == OP_MUL) || (op_is_divider(op) && (in_b != '0));
   assign run_last = (op_q == OP_MUL) ? (cnt_q == LAST) : div_done;
   assign div_start = accept && op_is_divider(op) && (in_b != '0);

   seq_divider #(.W(W), .CW(CW)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .dividend  (in_a),
      .divisor   (in_b),
      .iter_cnt  (cnt_q),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) state_d = go_run ? ST_RUN : ST_DONE;
            else        state_d = ST_IDLE;
         end
         ST_RUN:  if (run_last) state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
   end

   // Multiplier keeps {high partial, remaining multiplier bits} in one register.
   always_comb begin
      add_sum  = {1'b0, in_a} + {1'b0, in_b};
      sub_diff = {1'b0, in_a} - {1'b0, in_b};
      src_acc  = accept ? {{W{1'b0}}, in_b} : acc_q;
      src_a    = accept ? in_a : a_q;
      psum     = {1'b0, src_acc[2*W-1:W]} + {1'b0, (src_acc[0] ? src_a : {W{1'b0}})};
      step_acc = {psum, src_acc[W-1:1]};
   end

   always_comb begin
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      acc_d    = acc_q;
      result_d = result_q;
      dz_d     = dz_q;
      err_d    = err_q;
      if (accept) begin
         op_d  = op;
         a_d   = in_a;
         cnt_d = CW'(1);
         dz_d  = 1'b0;
         err_d = 1'b0;
         if (op == OP_MUL) acc_d = step_acc;
         if (!go_run) begin
            if (op == OP_ADD) begin
               result_d = {{(W-1){1'b0}}, add_sum};
            end else if (op == OP_SUB) begin
               result_d = {{(W-1){sub_diff[W]}}, sub_diff};
            end else if (op_is_divider(op)) begin
               result_d = '1;
               dz_d     = 1'b1;
            end else begin
               result_d = '0;
               err_d    = 1'b1;
            end
         end
      end else if (state_q == ST_RUN) begin
         if (!run_last) begin
            cnt_d = cnt_q + CW'(1);
            if (op_q == OP_MUL) acc_d = step_acc;
         end else if (op_q == OP_MUL) begin
            result_d = acc_q;
         end else if (op_q == OP_DIV) begin
            result_d = {{W{1'b0}}, div_quo};
         end else begin
            result_d = {{W{1'b0}}, div_rem};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         op_q     <= OP_ADD;
         a_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         dz_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         dz_q     <= dz_d;
         err_q    <= err_d;
      end
   end

   assign result = result_q;
   assign dz     = dz_q;
   assign err    = err_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed table-driven bench for iter_alu (W=8) plus handshake and reset sequences.
module tb_iter_alu;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst, start;
   logic [2:0]     op;
   logic [W-1:0]   in_a, in_b;
   logic           busy, done, dz, err;
   logic [2*W-1:0] result;

   always #5 clk = ~clk;

   iter_alu #(.W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .in_a   (in_a),
      .in_b   (in_b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .dz     (dz),
      .err    (err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] res;
      logic        dz;
      logic        err;
      int          lat;
      int          nbusy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   // Starts an operation now (accepted on the next edge), scrambles the inputs afterwards,
   // and waits for done. lat is in edges from the accept edge, counting the accept edge as 1.
   task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] r, output logic d, output logic e,
                         output int lat, output int nbusy, output logic [1:0] first_flags,
                         output bit ok);
      op = o; in_a = a; in_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = 3'b000; in_a = ~a; in_b = ~b;
      first_flags = {dz, err};
      lat = 1; nbusy = 0; ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) nbusy++;
         @(posedge clk); #1;
         lat++;
      end
      r = result; d = dz; e = err;
      $display("op=%0b a=%0d b=%0d -> result=0x%04h dz=%0b err=%0b lat=%0d busy=%0d",
               o, a, b, r, d, e, lat, nbusy);
   endtask

   task automatic check_vec(input int idx, input vec_t v);
      logic [15:0] r;
      logic        d, e;
      int          lat, nb;
      logic [1:0]  ff;
      bit          ok;
      run_op(v.op, v.a, v.b, r, d, e, lat, nb, ff, ok);
      if (!ok) begin
         check("timeout", idx, 0, 1);
      end else begin
         check("result", idx, 32'(r), 32'(v.res));
         check("dz", idx, 32'(d), 32'(v.dz));
         check("err", idx, 32'(e), 32'(v.err));
         check("latency", idx, lat, v.lat);
         check("busy_cycles", idx, nb, v.nbusy);
         if (v.lat > 1) check("flags_cleared", idx, 32'(ff), 0);
      end
   endtask

   initial begin
      logic [15:0] r;
      logic        d, e;
      int          lat, nb, ndone;
      logic [1:0]  ff;
      bit          ok;

      vecs.push_back('{3'b000, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 1, 0});
      vecs.push_back('{3'b000, 8'd255, 8'd255, 16'h01FE, 1'b0, 1'b0, 1, 0});
      vecs.push_back('{3'b001, 8'd5,   8'd9,   16'hFFFC, 1'b0, 1'b0, 1, 0});
      vecs.push_back('{3'b001, 8'd9,   8'd5,   16'h0004, 1'b0, 1'b0, 1, 0});
      vecs.push_back('{3'b010, 8'd13,  8'd0,   16'hFFFF, 1'b1, 1'b0, 1, 0});
      vecs.push_back('{3'b011, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 9, 8});
      vecs.push_back('{3'b011, 8'd12,  8'd13,  16'h009C, 1'b0, 1'b0, 9, 8});
      vecs.push_back('{3'b011, 8'd0,   8'd77,  16'h0000, 1'b0, 1'b0, 9, 8});
      vecs.push_back('{3'b011, 8'd200, 8'd100, 16'h4E20, 1'b0, 1'b0, 9, 8});
      vecs.push_back('{3'b010, 8'd200, 8'd7,   16'h001C, 1'b0, 1'b0, 9, 8});
      vecs.push_back('{3'b100, 8'd200, 8'd7,   16'h0004, 1'b0, 1'b0, 9, 8});
      vecs.push_back('{3'b010, 8'd255, 8'd1,   16'h00FF, 1'b0, 1'b0, 9, 8});
      vecs.push_back('{3'b100, 8'd5,   8'd9,   16'h0005, 1'b0, 1'b0, 9, 8});
      vecs.push_back('{3'b010, 8'd254, 8'd255, 16'h0000, 1'b0, 1'b0, 9, 8});
      vecs.push_back('{3'b100, 8'd254, 8'd255, 16'h00FE, 1'b0, 1'b0, 9, 8});
      vecs.push_back('{3'b010, 8'd255, 8'd16,  16'h000F, 1'b0, 1'b0, 9, 8});
      vecs.push_back('{3'b100, 8'd13,  8'd0,   16'hFFFF, 1'b1, 1'b0, 1, 0});
      vecs.push_back('{3'b110, 8'd1,   8'd1,   16'h0000, 1'b0, 1'b1, 1, 0});
      vecs.push_back('{3'b101, 8'd7,   8'd3,   16'h0000, 1'b0, 1'b1, 1, 0});
      vecs.push_back('{3'b111, 8'd9,   8'd9,   16'h0000, 1'b0, 1'b1, 1, 0});

      rst = 1'b1; start = 1'b1; op = 3'b000; in_a = 8'd1; in_b = 8'd1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 0, 32'(busy), 0);
      check("reset_done", 0, 32'(done), 0);
      check("reset_result", 0, 32'(result), 0);
      check("reset_dz", 0, 32'(dz), 0);
      check("reset_err", 0, 32'(err), 0);
      rst = 1'b0; start = 1'b0;

      // Vector 0 starts on the first edge after reset release; done pulse width and hold follow each.
      foreach (vecs[i]) begin
         check_vec(i, vecs[i]);
         @(posedge clk); #1;
         check("done_width", i, 32'(done), 0);
         check("result_hold", i, 32'(result), 32'(vecs[i].res));
      end

      // Start held high during a multiply must yield exactly one done with the first operands.
      op = 3'b011; in_a = 8'd3; in_b = 8'd4; start = 1'b1;
      @(posedge clk); #1;
      op = 3'b000; in_a = 8'd100; in_b = 8'd100;
      ndone = 0; r = '0;
      for (int k = 0; k < 20; k++) begin
         if (done) begin
            ndone++;
            if (ndone == 1) r = result;
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      $display("held-start mul 3*4 -> dones=%0d result=0x%04h", ndone, r);
      check("held_start_dones", 0, ndone, 1);
      check("held_start_result", 0, 32'(r), 32'h000C);

      // Back-to-back: each new start is issued in the previous op's DONE cycle.
      run_op(3'b011, 8'd255, 8'd255, r, d, e, lat, nb, ff, ok);
      check("b2b_mul_result", 0, 32'(r), 32'hFE01);
      check("b2b_mul_lat", 0, lat, 9);
      run_op(3'b010, 8'd200, 8'd7, r, d, e, lat, nb, ff, ok);
      check("b2b_div_result", 1, 32'(r), 32'h001C);
      check("b2b_div_lat", 1, lat, 9);
      check("b2b_div_busy", 1, nb, 8);
      run_op(3'b000, 8'd200, 8'd100, r, d, e, lat, nb, ff, ok);
      check("b2b_add_result", 2, 32'(r), 32'h012C);
      check("b2b_add_lat", 2, lat, 1);
      run_op(3'b100, 8'd200, 8'd7, r, d, e, lat, nb, ff, ok);
      check("b2b_mod_result", 3, 32'(r), 32'h0004);
      @(posedge clk); #1;

      // Reset asserted at T0+4 of a multiply aborts it silently.
      op = 3'b011; in_a = 8'd255; in_b = 8'd255; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("pre_reset_busy", 0, 32'(busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      $display("reset mid-mul -> busy=%0b done=%0b result=0x%04h", busy, done, result);
      check("abort_busy", 0, 32'(busy), 0);
      check("abort_done", 0, 32'(done), 0);
      check("abort_result", 0, 32'(result), 0);
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         if (done || busy) ndone++;
         @(posedge clk); #1;
      end
      check("abort_no_done", 0, ndone, 0);
      check("abort_result_stays", 0, 32'(result), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning operand width in bits (legal range 4..16).
REQ-002 The block SHALL have port clk  input  1  single system clock, rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  operation request, sampled on rising clk.
REQ-005 The block SHALL have port op  input  3  operation select: 000 add, 001 sub, 010 div, 011 mul, 100 mod, 101..111 illegal.
REQ-006 The block SHALL have port in_a  input  W  unsigned operand A.
REQ-007 The block SHALL have port in_b  input  W  unsigned operand B.
REQ-008 The block SHALL have port busy  output  1  operation in progress; start is not accepted.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port result  output  2W  registered result.
REQ-011 The block SHALL have port dz  output  1  divide/modulo by zero flag, valid with done.
REQ-012 The block SHALL have port err  output  1  illegal-op flag, valid with done.

Function
REQ-013 Accept: start=1 while busy=0 at a rising edge (T0) SHALL latch op, in_a and in_b; inputs after T0 SHALL be ignored.
REQ-014 start=1 while busy=1 SHALL be ignored: no state change and no queuing.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; IDLE->RUN on accept of div/mul/mod with in_b!=0; IDLE->DONE on accept of add, sub, illegal op, or div/mod with in_b=0; RUN->DONE after W iteration cycles; DONE->IDLE unconditionally after one cycle.
REQ-016 done SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-017 Latency SHALL be: done visible after edge T0+1 for add, sub, illegal op and divide-by-zero; after edge T0+W+1 for mul, div and mod.
REQ-018 A new start in the DONE cycle SHALL be accepted, giving back-to-back operation.
REQ-019 add: result SHALL equal A+B, zero-extended to 2W.
REQ-020 sub: result SHALL equal A-B as 2W-bit two's complement, sign-extended from bit W.
REQ-021 mul: result SHALL equal the full A*B product via shift-add, one partial product per cycle, with no truncation.
REQ-022 div: result SHALL equal floor(A/B), zero-extended, computed by restoring division at one quotient bit per cycle.
REQ-023 mod: result SHALL equal A mod B, zero-extended, using the same divider datapath.
REQ-024 div/mod with B=0: result SHALL be all ones and dz=1.
REQ-025 Illegal op: result SHALL be 0 and err=1.
REQ-026 dz and err SHALL clear on the next accepted start.
REQ-027 result SHALL update only on the edge entering DONE and hold until the next DONE.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, result=0, dz=0 and err=0, overriding start.
REQ-029 rst during RUN or DONE SHALL abort the operation with no done pulse and no partial result visible.
REQ-030 The first start SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-031 Shared package alu_pkg SHALL hold the op-code constants (OP_ADD, OP_SUB, OP_DIV, OP_MUL, OP_MOD) and the FSM state type.
REQ-032 The restoring divider SHALL be a sub-module seq_divider (start/done interface, quotient and remainder outputs); the multiplier and add/sub SHALL live in iter_alu.
REQ-033 The only shared iteration counter SHALL be ceil(log2(W+1)) bits wide.

Verification (W=8)
REQ-034 add: A=200, B=100 -> after T0+1: result=0x012C, done=1 for one cycle.
REQ-035 sub and mul: A=5, B=9 sub -> 0xFFFC; A=255, B=255 mul -> 0xFE01, busy=1 for 8 cycles, done after T0+9.
REQ-036 div/mod: A=200, B=7 -> div 0x001C, mod 0x0004; A=13, B=0 div -> 0xFFFF, dz=1, done after T0+1.
REQ-037 Handshake: start held high during mul -> only one done; new start in the DONE cycle -> accepted with correct back-to-back results.
REQ-038 Reset mid-mul: rst at T0+4 -> next cycle busy=0, done=0, result=0; no done pulse follows.
REQ-039 Illegal op 110, A=1, B=1 -> after T0+1: result=0, err=1, dz=0.
